cipher_arbiter: RTL and testbench
=================================

Name: cipher_arbiter

Overview:
Shares one `cipher` instance (128-bit block, 32*Nk-bit key) between NUM_REQ requesters, such as SPI slave front-ends or a test port. Arbitration is round-robin. The block registers the winner's block and key onto the cipher inputs and waits a fixed number of cycles for the cipher to settle. It then captures the ciphertext and returns it tagged with the requester ID over a valid/ready response channel. Only one encryption is in flight at a time.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8).
- Nr, 10, round count; passed to cipher.
- NUM_REQ, 4, number of requesters (2..8).
- SETTLE_CYC, 2, cycles between cipher-input load and result capture (≥1).

Ports:
- clk, input, 1, system clock; all flops on posedge.
- rst, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, per-requester request strobe.
- req_ready, output, NUM_REQ, one-hot grant acknowledge; request accepted when valid & ready.
- req_data, input, 128*NUM_REQ, plaintext; requester k occupies [128k+127:128k].
- req_key, input, 32*Nk*NUM_REQ, key; requester k occupies slice k.
- rsp_valid, output, 1, ciphertext available.
- rsp_ready, input, 1, consumer accepts response.
- rsp_data, output, 128, ciphertext.
- rsp_id, output, clog2(NUM_REQ), index of the originating requester.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - Round-robin pointer=0; cipher input registers=0; settle counter=0.
- FSM states: IDLE → GRANT → SETTLE → RESP → IDLE.
- IDLE:
  - If any req_valid is high, pick the first set bit searching from pointer upward with wrap (pointer itself has top priority) and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle):
  - req_ready[winner]=1 combinationally; all other bits are 0.
  - On the clock edge, register req_data and req_key of the winner into the cipher input registers and latch winner into rsp_id.
  - Pointer becomes (winner+1) mod NUM_REQ.
  - Counter loads SETTLE_CYC-1; go to SETTLE.
  - If req_valid[winner] drops during GRANT, the request is still taken. Requesters must hold valid until ready.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture the cipher output into rsp_data, set rsp_valid=1 and go to RESP.
  - Load-to-capture latency is exactly SETTLE_CYC cycles.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready=1.
  - On the handshake edge, clear rsp_valid and go to IDLE.
  - If rsp_ready is already high on entry, exit after one cycle.
- Latency and throughput:
  - Best case, req_valid to rsp_valid: 2 + SETTLE_CYC cycles.
  - Back-to-back throughput: one request per 3 + SETTLE_CYC cycles (IDLE, GRANT, SETTLE, RESP).
- Boundary conditions:
  - Multiple simultaneous requests: round-robin guarantees each waiting requester is served within NUM_REQ grants.
  - Pointer wraps from NUM_REQ-1 to 0.
  - Requests arriving while busy wait; nothing is dropped or queued internally.
  - Reset mid-operation aborts immediately: no response is produced and the pointer returns to 0.
  - Key width and data slicing are fixed by Nk; no run-time key-size switching.

Optional Feature:
- FIXED_PRIO_EN defined: the round-robin pointer is removed and the lowest-index valid requester always wins. This gives deterministic priority for a host debug port on index 0.
- FIXED_PRIO_EN undefined: round-robin as specified above.

Decomposition:
- Shared package/include `cipher_arb_defs.vh` holds:
  - state encodings (IDLE=2'd0, GRANT=2'd1, SETTLE=2'd2, RESP=2'd3);
  - the clog2 function;
  - the BLK_W=128 constant.
- One natural sub-module, `rr_pick`: combinational round-robin picker taking the valid vector and pointer and returning a one-hot winner and its index.
- `cipher` is instantiated inside cipher_arbiter.

Test Plan:
1. Single request: req_valid=4'b0010, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f (Nk=4) → rsp_valid after 2+SETTLE_CYC cycles, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=1.
2. All four requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,…; each rsp_id matches its grant; no requester is granted twice before the others are served.
3. Backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid, rsp_data and rsp_id stay stable and no new req_ready is asserted; on release, one handshake, then return to IDLE.
4. Reset asserted during SETTLE → rsp_valid=0, busy=0 immediately; after release, req_valid=4'b1000 is granted (pointer back at 0, searching upward).
5. With FIXED_PRIO_EN, req_valid=4'b1111 held for three responses → rsp_id=0 every time.
6. Nk=8 build with the FIPS-197 AES-256 vector → rsp_data=8ea2b7ca516745bfeafc49904b496089.

Source files
------------

// File: rtl/cipher_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cipher_arbiter_pkg
//   Shared definitions for the cipher arbiter:
//     - arb_state_e : FSM state encoding (IDLE/GRANT/SETTLE/RESP)
//     - BLK_W       : cipher block width in bits
//     - clog2()     : constant ceil(log2) helper used for index widths
// -----------------------------------------------------------------------------
package cipher_arbiter_pkg;

    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // ceil(log2(v)); returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/cipher_arbiter_cipher.sv
// -----------------------------------------------------------------------------
// cipher
//   Purely combinational AES block encryption (FIPS-197), key of Nk 32-bit
//   words and Nr rounds. Byte 0 of the block/key is the most significant byte.
//   The S-box is computed arithmetically (GF(2^8) inverse + affine map).
//   Ports:
//     blk_i [127:0]     plaintext
//     key_i [32*Nk-1:0] cipher key
//     blk_o [127:0]     ciphertext
// -----------------------------------------------------------------------------
module cipher #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic [127:0]     blk_i,
    input  logic [32*Nk-1:0] key_i,
    output logic [127:0]     blk_o
);

    localparam int NW = 4 * (Nr + 1);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0]  inv;
        logic [7:0]  base;
        logic [15:0] r;
        // a^254 == a^-1 in GF(2^8) (and maps 0 to 0): exponent bits 1..7.
        inv  = 8'h01;
        base = a;
        for (int i = 1; i < 8; i++) begin
            base = gmul(base, base);
            inv  = gmul(inv, base);
        end
        r = {inv, inv};
        return inv ^ r[14 -: 8] ^ r[13 -: 8] ^ r[12 -: 8] ^ r[11 -: 8] ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                             input logic [32*Nk-1:0] key);
        logic [31:0]  w [NW];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;

        // Key schedule
        rc = 8'h01;
        for (int i = 0; i < NW; i++) begin
            if (i < Nk) begin
                w[i] = key[32*(Nk-1-i) +: 32];
            end else begin
                tmp = w[i-1];
                if (i % Nk == 0) begin
                    tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                    rc  = xtime(rc);
                end else if (Nk > 6 && i % Nk == 4) begin
                    tmp = sub_word(tmp);
                end
                w[i] = w[i-Nk] ^ tmp;
            end
        end

        // State byte j = row (j%4), column (j/4)
        for (int j = 0; j < 16; j++) begin
            s[j] = pt[127-8*j -: 8];
            t[j] = 8'h00;
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                s[4*c+k] = s[4*c+k] ^ w[c][31-8*k -: 8];
            end
        end

        for (int r = 1; r <= Nr; r++) begin
            for (int j = 0; j < 16; j++) begin
                t[j] = sbox(s[j]);
            end
            // ShiftRows: row rr rotates left by rr columns
            for (int c = 0; c < 4; c++) begin
                for (int rr = 0; rr < 4; rr++) begin
                    s[rr+4*c] = t[rr+4*((c+rr)%4)];
                end
            end
            if (r != Nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c];
                    a1 = s[4*c+1];
                    a2 = s[4*c+2];
                    a3 = s[4*c+3];
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < 4; k++) begin
                    s[4*c+k] = s[4*c+k] ^ w[4*r+c][31-8*k -: 8];
                end
            end
        end

        res = '0;
        for (int j = 0; j < 16; j++) begin
            res[127-8*j -: 8] = s[j];
        end
        return res;
    endfunction

    assign blk_o = aes_enc(blk_i, key_i);

endmodule

// File: rtl/cipher_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches valid_i starting at ptr_i and
//   wrapping; the pointer position itself has top priority.
//   Ports:
//     valid_i  [N-1:0]  request vector
//     ptr_i    [IW-1:0] search start index (always < N)
//     onehot_o [N-1:0]  one-hot winner (zero when nothing valid)
//     idx_o    [IW-1:0] binary index of the winner
//     any_o             at least one request valid
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Walk the offsets from farthest to nearest; a later (closer) hit
    // overwrites an earlier one, so the first set bit from ptr_i wins.
    always_comb begin
        int k;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        k        = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr_i) + i) % N;
            if (valid_i[k]) begin
                onehot_o    = '0;
                onehot_o[k] = 1'b1;
                idx_o       = IW'(k);
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cipher_arbiter.sv
// -----------------------------------------------------------------------------
// cipher_arbiter
//   Shares one combinational cipher between NUM_REQ requesters. A winner is
//   picked in IDLE, acknowledged for one GRANT cycle while its block/key are
//   registered onto the cipher inputs, the cipher is given SETTLE_CYC cycles,
//   then the ciphertext is presented on the response channel tagged with the
//   requester index. One encryption in flight at a time.
//
//   Build option: define FIXED_PRIO_EN to drop the round-robin pointer so the
//   lowest-index valid requester always wins.
//
//   Ports:
//     clk                         clock, posedge
//     rst                         asynchronous reset, active low
//     req_valid [NUM_REQ-1:0]     request strobes
//     req_ready [NUM_REQ-1:0]     one-hot acknowledge (GRANT state only)
//     req_data  [128*NUM_REQ-1:0] plaintexts, requester k at [128k +: 128]
//     req_key   [32*Nk*NUM_REQ-1:0] keys, requester k at [32*Nk*k +: 32*Nk]
//     rsp_valid / rsp_ready       response handshake
//     rsp_data  [127:0]           ciphertext
//     rsp_id    [clog2(NUM_REQ)-1:0] originating requester
//     busy                        FSM not in IDLE
// -----------------------------------------------------------------------------
module cipher_arbiter
    import cipher_arbiter_pkg::*;
#(
    parameter int Nk         = 4,
    parameter int Nr         = 10,
    parameter int NUM_REQ    = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [BLK_W*NUM_REQ-1:0]      req_data,
    input  logic [32*Nk*NUM_REQ-1:0]      req_key,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [BLK_W-1:0]              rsp_data,
    output logic [clog2(NUM_REQ)-1:0]     rsp_id,
    output logic                          busy
);

    localparam int ID_W  = clog2(NUM_REQ);
    localparam int KEY_W = 32 * Nk;
    localparam int CNT_W = clog2(SETTLE_CYC) + 1;

    // Per-requester views of the flat data/key buses
    logic [BLK_W-1:0] data_arr [NUM_REQ];
    logic [KEY_W-1:0] key_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*BLK_W +: BLK_W];
        assign key_arr[gi]  = req_key[gi*KEY_W +: KEY_W];
    end

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    win_idx_q, win_idx_d;
    logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [BLK_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] pick_oh;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [BLK_W-1:0]   cipher_out;

`ifdef FIXED_PRIO_EN
    // Search always starts at index 0: lowest valid index wins.
    assign ptr = '0;
`else
    logic [ID_W-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .valid_i  (req_valid),
        .ptr_i    (ptr),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    cipher #(
        .Nk (Nk),
        .Nr (Nr)
    ) u_cipher (
        .blk_i (blk_q),
        .key_i (key_q),
        .blk_o (cipher_out)
    );

    always_comb begin
        state_d     = state_q;
        win_idx_d   = win_idx_q;
        win_oh_d    = win_oh_q;
        blk_d       = blk_q;
        key_d       = key_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
`ifndef FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        req_ready   = '0;

        unique case (state_q)
            IDLE: begin
                // Winner is frozen here so GRANT is immune to valid changes.
                if (pick_any) begin
                    win_idx_d = pick_idx;
                    win_oh_d  = pick_oh;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                req_ready = win_oh_q;
                blk_d     = data_arr[win_idx_q];
                key_d     = key_arr[win_idx_q];
                rsp_id_d  = win_idx_q;
`ifndef FIXED_PRIO_EN
                ptr_d     = (win_idx_q == ID_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
`endif
                cnt_d     = CNT_W'(SETTLE_CYC - 1);
                state_d   = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = cipher_out;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            win_idx_q   <= '0;
            win_oh_q    <= '0;
            blk_q       <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
`ifndef FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            win_idx_q   <= win_idx_d;
            win_oh_q    <= win_oh_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
`ifndef FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cipher_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cipher_arbiter
//   Directed bench for cipher_arbiter. Main instance: Nk=4, 4 requesters,
//   SETTLE_CYC=2, each requester carrying a known AES-128 vector. A second
//   instance (Nk=8, Nr=14, 2 requesters) checks the AES-256 vector.
//   Expectations follow FIXED_PRIO_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_cipher_arbiter;

    localparam int NUM_REQ = 4;

`ifdef FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    localparam logic [127:0] PT0  = 128'h0;
    localparam logic [127:0] KEY0 = 128'h0;
    localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT3  = 128'h80000000000000000000000000000000;
    localparam logic [127:0] KEY3 = 128'h0;
    localparam logic [127:0] CT3  = 128'h3ad78e726c1ec02b7ebfe92b23d9ec34;
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance
    logic [NUM_REQ-1:0]     req_valid, req_ready;
    logic [128*NUM_REQ-1:0] req_data;
    logic [128*NUM_REQ-1:0] req_key;
    logic                   rsp_valid, rsp_ready, busy;
    logic [127:0]           rsp_data;
    logic [1:0]             rsp_id;

    // AES-256 instance
    logic [1:0]   req_valid2, req_ready2;
    logic [255:0] req_data2;
    logic [511:0] req_key2;
    logic         rsp_valid2, rsp_ready2, busy2;
    logic [127:0] rsp_data2;
    logic [0:0]   rsp_id2;

    cipher_arbiter #(.Nk(4), .Nr(10), .NUM_REQ(NUM_REQ), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    cipher_arbiter #(.Nk(8), .Nr(14), .NUM_REQ(2), .SETTLE_CYC(2)) dut256 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_data(req_data2), .req_key(req_key2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_data(rsp_data2), .rsp_id(rsp_id2), .busy(busy2)
    );

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [127:0] ct_tab [4];
    int           exp_order [8];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with rsp_ready held high.
    task automatic run_one(input string tag, input logic [3:0] v, input int exp_id);
        req_valid = v;
        step();
        check({tag, "_grant"}, req_ready, 4'b0001 << exp_id);
        step();
        req_valid = '0;
        step();
        step();
        $display("[%0t] %s: rsp_valid=%b rsp_id=%0d rsp_data=%h", $time, tag, rsp_valid, rsp_id, rsp_data);
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_id"}, rsp_id, exp_id);
        check({tag, "_data"}, rsp_data, ct_tab[exp_id]);
        step();
        check({tag, "_idle"}, {rsp_valid, busy}, 2'b00);
    endtask

    initial begin
        int g, r, last, bp_next, n;
        logic [127:0] held;

        ct_tab[0] = CT0;
        ct_tab[1] = CT1;
        ct_tab[2] = CT2;
        ct_tab[3] = CT3;
        for (int i = 0; i < 8; i++) exp_order[i] = FIXED ? 0 : (i % 4);

        rst        = 1'b0;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        req_data   = {PT3, PT2, PT1, PT0};
        req_key    = {KEY3, KEY2, KEY1, KEY0};
        req_valid2 = '0;
        rsp_ready2 = 1'b0;
        req_data2  = {PT1, 128'h0};
        req_key2   = {KEY256, 256'h0};

        // Reset state
        step();
        step();
        check("rst_ready", req_ready, 4'b0000);
        check("rst_valid_busy", {rsp_valid, busy}, 2'b00);
        check("rst_data", rsp_data, 128'h0);
        check("rst_id", rsp_id, 2'd0);
        check("rst_data256", rsp_data2, 128'h0);
        rst = 1'b1;
        step();

        // All requesters valid, rsp_ready high: fair order, period 5
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        g = 0; r = 0; last = 0;
        for (int cyc = 1; cyc <= 60 && r < 5; cyc++) begin
            step();
            if (req_ready != '0 && g < 8) begin
                $display("[%0t] rr: grant req_ready=%b", $time, req_ready);
                check("rr_grant", req_ready, 4'b0001 << exp_order[g]);
                if (g > 0) check("rr_period", cyc - last, 5);
                last = cyc;
                g++;
            end
            if (rsp_valid) begin
                $display("[%0t] rr: rsp_id=%0d rsp_data=%h", $time, rsp_id, rsp_data);
                check("rr_id", rsp_id, exp_order[r]);
                check("rr_data", rsp_data, ct_tab[exp_order[r]]);
                r++;
            end
        end
        req_valid = '0;
        check("rr_count", r, 5);
        step();
        check("rr_idle", busy, 1'b0);

        // Single request on requester 1: exact latency 2+SETTLE_CYC
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        step();
        check("t1_grant", req_ready, 4'b0010);
        check("t1_busy", busy, 1'b1);
        step();
        req_valid = '0;
        check("t1_settle", {req_ready, rsp_valid}, 5'b0);
        step();
        check("t1_early", rsp_valid, 1'b0);
        step();
        $display("[%0t] t1: rsp_valid=%b rsp_id=%0d rsp_data=%h", $time, rsp_valid, rsp_id, rsp_data);
        check("t1_valid", rsp_valid, 1'b1);
        check("t1_data", rsp_data, CT1);
        check("t1_id", rsp_id, 2'd1);

        // Backpressure for 10 cycles with everyone requesting
        held = rsp_data;
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold", {rsp_valid, rsp_id, req_ready, busy}, {1'b1, 2'd1, 4'b0000, 1'b1});
            check("bp_data", rsp_data, held);
        end
        $display("[%0t] bp: released after 10 stalled cycles", $time);
        rsp_ready = 1'b1;
        step();
        check("bp_release", {rsp_valid, busy, req_ready}, 6'b0);
        bp_next = FIXED ? 0 : 2;
        step();
        check("bp_next_grant", req_ready, 4'b0001 << bp_next);
        step();
        req_valid = '0;
        step();
        step();
        check("bp_next_id", {rsp_valid, rsp_id}, {1'b1, 2'(bp_next)});
        check("bp_next_data", rsp_data, ct_tab[bp_next]);
        step();

        // Reset during SETTLE aborts at once and returns pointer to 0
        req_valid = 4'b0010;
        step();
        check("rs_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        check("rs_in_settle", busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        $display("[%0t] rs: async reset in SETTLE busy=%b rsp_valid=%b", $time, busy, rsp_valid);
        check("rs_async", {rsp_valid, busy}, 2'b00);
        check("rs_id", rsp_id, 2'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rs_no_rsp", {rsp_valid, busy}, 2'b00);
        end
        run_one("rs_ptr", 4'b1010, 1);
        run_one("rs_top", 4'b1000, 3);
        run_one("zero_vec", 4'b0001, 0);

        // AES-256 instance, requester 1
        req_valid2 = 2'b10;
        rsp_ready2 = 1'b1;
        step();
        check("a256_grant", req_ready2, 2'b10);
        req_valid2 = 2'b00;
        n = 1;
        while (!rsp_valid2 && n < 12) begin
            step();
            n++;
        end
        $display("[%0t] a256: rsp_valid=%b rsp_id=%0d rsp_data=%h", $time, rsp_valid2, rsp_id2, rsp_data2);
        check("a256_latency", n, 4);
        check("a256_data", rsp_data2, CT256);
        check("a256_id", rsp_id2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
